// File: rtl/ctech_lib_sync_pkg.sv
// Shared limits and helpers for the multi-channel synchroniser / glitch filter.
// Imported by the top (range checks) and the per-channel module (counter width).
package ctech_lib_sync_pkg;

    localparam int SYNC_STAGES_MIN   = 2;
    localparam int SYNC_STAGES_MAX   = 4;
    localparam int FILTER_CYCLES_MAX = 255;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int filt_cnt_w(int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ctech_lib_sync_filter_chan.sv
// One channel: flop-only sync chain, stability counter, registered level,
// edge pulses and a sticky event flag.
module ctech_lib_sync_filter_chan
    import ctech_lib_sync_pkg::*;
#(
    parameter int   STAGES        = 3,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    input  logic evt_clr,
    output logic o,
    output logic rise,
    output logic fall,
    output logic evt
);

    localparam int             CW      = filt_cnt_w(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CYCLES);

    logic [STAGES-1:0] sync_q;
    logic              s;
    logic [CW-1:0]     cnt;
    logic              toggle;

    // Chain is kept in its own block with nothing but flops so CDC tools
    // recognise it as a synchroniser.
    if (STAGES >= 2) begin : g_sync_chain
        // NOTE: the sync flops are reset too, so s (and therefore o) is defined
        // the first cycle after release instead of carrying stale X values.
        always_ff @(posedge clk) begin
            if (!rstb) begin
                sync_q <= {STAGES{RST_VAL}};
            end else begin
                sync_q <= {sync_q[STAGES-2:0], d};
            end
        end
    end

    assign s      = sync_q[STAGES-1];
    assign toggle = (s != o) && (cnt == CNT_MAX);

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of o and cnt, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt  <= '0;
            o    <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
            evt  <= 1'b0;
        end else begin
            if (s == o || toggle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (toggle) begin
                o <= s;
            end
            rise <= toggle & s;
            fall <= toggle & ~s;
            // A toggle on the same edge as a clear keeps the flag set.
            evt  <= toggle | (evt & ~evt_clr);
        end
    end

endmodule

// File: rtl/ctech_lib_sync_filter.sv
// Multi-channel reset/status synchroniser with per-channel glitch filter,
// edge pulses and sticky events; channels are fully independent.
module ctech_lib_sync_filter
    import ctech_lib_sync_pkg::*;
#(
    parameter int   WIDTH         = 1,
    parameter int   STAGES        = 3,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt
);

    if (WIDTH < 1) begin : g_bad_width
        $error("ctech_lib_sync_filter: WIDTH must be at least 1");
    end
    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("ctech_lib_sync_filter: STAGES out of range 2..4");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filter
        $error("ctech_lib_sync_filter: FILTER_CYCLES out of range 0..255");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        ctech_lib_sync_filter_chan #(
            .STAGES       (STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RST_VAL      (RST_VAL)
        ) u_chan (
            .clk    (clk),
            .rstb   (rstb),
            .d      (d[i]),
            .evt_clr(evt_clr[i]),
            .o      (o[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .evt    (evt[i])
        );
    end

endmodule

// File: tb/tb_ctech_lib_sync_filter.sv
// Bench for ctech_lib_sync_filter: three configurations checked every cycle
// against a sample-window reference model, plus hand-computed timing points.
module tb_ctech_lib_sync_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;

    // Unit A: WIDTH=4, STAGES=3, FILTER=0, RST_VAL=0
    logic [3:0] d_a, clr_a, o_a, rise_a, fall_a, evt_a;
    // Unit B: WIDTH=2, STAGES=2, FILTER=4, RST_VAL=0
    logic [1:0] d_b, clr_b, o_b, rise_b, fall_b, evt_b;
    // Unit C: WIDTH=8, STAGES=4, FILTER=2, RST_VAL=1
    logic [7:0] d_c, clr_c, o_c, rise_c, fall_c, evt_c;

    ctech_lib_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(0), .RST_VAL(1'b0)) u_dut_a (
        .clk(clk), .rstb(rstb), .d(d_a), .evt_clr(clr_a),
        .o(o_a), .rise(rise_a), .fall(fall_a), .evt(evt_a)
    );
    ctech_lib_sync_filter #(.WIDTH(2), .STAGES(2), .FILTER_CYCLES(4), .RST_VAL(1'b0)) u_dut_b (
        .clk(clk), .rstb(rstb), .d(d_b), .evt_clr(clr_b),
        .o(o_b), .rise(rise_b), .fall(fall_b), .evt(evt_b)
    );
    ctech_lib_sync_filter #(.WIDTH(8), .STAGES(4), .FILTER_CYCLES(2), .RST_VAL(1'b1)) u_dut_c (
        .clk(clk), .rstb(rstb), .d(d_c), .evt_clr(clr_c),
        .o(o_c), .rise(rise_c), .fall(fall_c), .evt(evt_c)
    );

    int   wd_cfg [3] = '{4, 2, 8};
    int   st_cfg [3] = '{3, 2, 4};
    int   fc_cfg [3] = '{0, 4, 2};
    logic rv_cfg [3] = '{1'b0, 1'b0, 1'b1};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: d history per channel, and the window of synchronised
    // samples seen since reset. o flips once the last FILTER+1 samples all
    // disagree with it.
    logic [7:0]  m_o    [3];
    logic [7:0]  m_rise [3];
    logic [7:0]  m_fall [3];
    logic [7:0]  m_evt  [3];
    logic [7:0]  m_dhist[3][8];
    logic [15:0] m_win  [3][8];
    int          m_nval [3][8];
    bit          started = 1'b0;

    task automatic model_step(input int u, input logic [7:0] dv, input logic [7:0] cv, input logic rst_n);
        logic s;
        logic tog;
        for (int c = 0; c < wd_cfg[u]; c++) begin
            if (!rst_n) begin
                m_dhist[u][c] = {8{rv_cfg[u]}};
                m_win[u][c]   = '0;
                m_nval[u][c]  = 0;
                m_o[u][c]     = rv_cfg[u];
                m_rise[u][c]  = 1'b0;
                m_fall[u][c]  = 1'b0;
                m_evt[u][c]   = 1'b0;
            end else begin
                s = m_dhist[u][c][st_cfg[u]-1];
                m_dhist[u][c] = {m_dhist[u][c][6:0], dv[c]};
                m_win[u][c]   = {m_win[u][c][14:0], s};
                if (m_nval[u][c] < 16) m_nval[u][c]++;
                tog = (m_nval[u][c] >= fc_cfg[u] + 1);
                for (int j = 0; j <= fc_cfg[u]; j++) begin
                    if (m_win[u][c][j] == m_o[u][c]) tog = 1'b0;
                end
                m_rise[u][c] = tog & s;
                m_fall[u][c] = tog & ~s;
                m_evt[u][c]  = tog | (m_evt[u][c] & ~cv[c]);
                if (tog) m_o[u][c] = s;
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            m_o[u] = '0; m_rise[u] = '0; m_fall[u] = '0; m_evt[u] = '0;
        end
    end

    always @(posedge clk) begin
        model_step(0, {4'b0, d_a}, {4'b0, clr_a}, rstb);
        model_step(1, {6'b0, d_b}, {6'b0, clr_b}, rstb);
        model_step(2, d_c, clr_c, rstb);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_o_a",    {4'b0, o_a},    m_o[0]);
            check("model_rise_a", {4'b0, rise_a}, m_rise[0]);
            check("model_fall_a", {4'b0, fall_a}, m_fall[0]);
            check("model_evt_a",  {4'b0, evt_a},  m_evt[0]);
            check("model_o_b",    {6'b0, o_b},    m_o[1]);
            check("model_rise_b", {6'b0, rise_b}, m_rise[1]);
            check("model_fall_b", {6'b0, fall_b}, m_fall[1]);
            check("model_evt_b",  {6'b0, evt_b},  m_evt[1]);
            check("model_o_c",    o_c,            m_o[2]);
            check("model_rise_c", rise_c,         m_rise[2]);
            check("model_fall_c", fall_c,         m_fall[2]);
            check("model_evt_c",  evt_c,          m_evt[2]);
            check("pulse_excl_c", rise_c & fall_c, 8'h00);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstb  = 1'b0;
        d_a   = 4'hF; clr_a = 4'h0;
        d_b   = 2'b00; clr_b = 2'b00;
        d_c   = 8'hFF; clr_c = 8'h00;

        // Reset hold with d away from the reset value
        repeat (10) begin
            tick(1);
            check("hold_o_a", {4'b0, o_a}, 8'h00);
            check("hold_flags_a", {4'b0, rise_a | fall_a | evt_a}, 8'h00);
        end

        // Release: o reaches 4'hF three edges later with one rise per channel
        rstb = 1'b1;
        tick(3);
        check("rel_o_a_early", {4'b0, o_a}, 8'h00);
        tick(1);
        check("rel_o_a",    {4'b0, o_a},    8'h0F);
        check("rel_rise_a", {4'b0, rise_a}, 8'h0F);
        check("rel_evt_a",  {4'b0, evt_a},  8'h0F);
        tick(1);
        check("rel_rise_a_end", {4'b0, rise_a}, 8'h00);
        check("rel_o_c", o_c, 8'hFF);

        // Drop unit A, then clear its sticky flags
        d_a = 4'h0;
        tick(5);
        clr_a = 4'hF;
        tick(1);
        clr_a = 4'h0;
        check("clr_evt_a", {4'b0, evt_a}, 8'h00);

        // Latency: d[0] 0->1 seen on o at E0+3
        d_a = 4'h1;
        tick(3);
        check("lat_o_a_early", {4'b0, o_a}, 8'h00);
        tick(1);
        check("lat_o_a",    {4'b0, o_a},    8'h01);
        check("lat_rise_a", {4'b0, rise_a}, 8'h01);
        check("lat_evt_a",  {4'b0, evt_a},  8'h01);
        tick(1);
        check("lat_rise_a_end", {4'b0, rise_a}, 8'h00);

        // Filter: 4-cycle glitch on unit B ch0 is swallowed
        for (int k = 0; k < 12; k++) begin
            d_b[0] = (k < 4);
            tick(1);
            check("glitch_o_b0", {7'b0, o_b[0]}, 8'h00);
            check("glitch_rise_b0", {7'b0, rise_b[0]}, 8'h00);
        end

        // Filter: 5-cycle high passes at E0+6, return low falls at E0+11
        for (int k = 0; k < 14; k++) begin
            d_b[0] = (k < 5);
            tick(1);
            if (k + 1 == 6)  check("filt_o_b0_early", {7'b0, o_b[0]}, 8'h00);
            if (k + 1 == 7) begin
                check("filt_o_b0",    {7'b0, o_b[0]},    8'h01);
                check("filt_rise_b0", {7'b0, rise_b[0]}, 8'h01);
            end
            if (k + 1 == 11) check("filt_o_b0_hold", {7'b0, o_b[0]}, 8'h01);
            if (k + 1 == 12) begin
                check("filt_o_b0_low", {7'b0, o_b[0]},    8'h00);
                check("filt_fall_b0",  {7'b0, fall_b[0]}, 8'h01);
            end
        end

        // Sticky collision on unit B ch1
        d_b[1] = 1'b1;
        tick(10);
        clr_b[1] = 1'b1;
        tick(1);
        clr_b[1] = 1'b0;
        check("pre_evt_b1", {7'b0, evt_b[1]}, 8'h00);
        check("pre_o_b1",   {7'b0, o_b[1]},   8'h01);
        d_b[1] = 1'b0;
        tick(6);
        clr_b[1] = 1'b1;
        tick(1);
        check("coll_fall_b1", {7'b0, fall_b[1]}, 8'h01);
        check("coll_evt_b1",  {7'b0, evt_b[1]},  8'h01);
        tick(1);
        clr_b[1] = 1'b0;
        check("lone_clr_evt_b1", {7'b0, evt_b[1]}, 8'h00);

        // Independence: distinct half-periods per bit on unit C
        for (int cyc = 0; cyc < 60; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                d_c[i] = ((cyc / (i + 2)) % 2) == 0;
            end
            clr_c = (cyc % 7 == 6) ? 8'(cyc * 37) : 8'h00;
            tick(1);
        end
        d_c   = 8'hFF;
        clr_c = 8'h00;
        tick(10);
        check("indep_o_c_settle", o_c, 8'hFF);

        // Reset mid-filter on unit B ch0 with cnt at 2
        d_b[0] = 1'b1;
        tick(4);
        rstb = 1'b0;
        tick(1);
        rstb = 1'b1;
        check("mid_rst_o_b",     {6'b0, o_b},             8'h00);
        check("mid_rst_flags_b", {6'b0, rise_b | fall_b | evt_b}, 8'h00);
        for (int n = 1; n <= 7; n++) begin
            tick(1);
            if (n < 7) begin
                check("restart_o_b0",    {7'b0, o_b[0]},    8'h00);
                check("restart_rise_b0", {7'b0, rise_b[0]}, 8'h00);
            end else begin
                check("restart_o_b0_set", {7'b0, o_b[0]},    8'h01);
                check("restart_rise_b0_set", {7'b0, rise_b[0]}, 8'h01);
            end
        end

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
